button_event_gen: RTL

- Front-end producer of the one-hot button-event pulses (inc_short, inc_long, set, sw) consumed by the clock/alarm/stopwatch mode FSM.
- Synchronises and debounces three raw push-buttons.
- Classifies INC presses as short or long by hold time.
- Arbitrates events so that at most one output pulse is high in any cycle; a colliding event is queued and issued later, never dropped.

---
 rtl/button_event_gen_if.sv | 12 +
 rtl/button_event_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/button_event_gen_if.sv
// Button-event pulse bundle from the debounce/classify front end to the mode FSM.
// All pulses are one cycle wide and mutually exclusive.
interface button_event_gen_if;
  logic inc_short;
  logic inc_long;
  logic set;
  logic sw;
  logic event_pending;

  modport master (output inc_short, inc_long, set, sw, event_pending);
  modport slave  (input  inc_short, inc_long, set, sw, event_pending);
endinterface

// File: rtl/button_event_gen.sv
// Synchronises and debounces INC/SET/SW, classifies INC short/long presses and
// serialises the resulting events into one-hot single-cycle pulses.
module button_event_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES     = 64,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_inc,
  input  logic               btn_set,
  input  logic               btn_sw,
  button_event_gen_if.master evt
);

  localparam int NB      = 3;
  localparam int IDX_INC = 0;
  localparam int IDX_SET = 1;
  localparam int IDX_SW  = 2;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Pending vector bit order doubles as priority: set > sw > inc_long > inc_short.
  localparam int P_SHORT = 0;
  localparam int P_LONG  = 1;
  localparam int P_SW    = 2;
  localparam int P_SET   = 3;

  logic [NB-1:0] raw, s1, s2, stable, flip_c;

  assign raw = {btn_sw, btn_set, btn_inc};

  // Two-flop synchronisers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  genvar g;
  for (g = 0; g < NB; g++) begin : g_db
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    assign stable[g] = stable_q;
    assign flip_c[g] = (s2[g] != stable_q) && (cnt_q == DB_LAST);

    // Stable level flips after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else if (s2[g] == stable_q) begin
        cnt_q <= '0;
      end else if (flip_c[g]) begin
        stable_q <= s2[g];
        cnt_q    <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  logic inc_rise_c, inc_fall_c, set_rise_c, sw_rise_c;

  assign inc_rise_c = flip_c[IDX_INC] &  s2[IDX_INC];
  assign inc_fall_c = flip_c[IDX_INC] & ~s2[IDX_INC];
  assign set_rise_c = flip_c[IDX_SET] &  s2[IDX_SET];
  assign sw_rise_c  = flip_c[IDX_SW]  &  s2[IDX_SW];

  typedef enum logic [1:0] {
    INC_IDLE = 2'd0,
    INC_HOLD = 2'd1,
    INC_LONG = 2'd2
  } inc_state_e;

  inc_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             ev_short_c, ev_long_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INC_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // INC press classifier: a release wins over reaching the long threshold
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    ev_short_c = 1'b0;
    ev_long_c  = 1'b0;
    case (state_q)
      INC_IDLE: begin
        if (inc_rise_c) begin
          state_d = INC_HOLD;
          hold_d  = '0;
        end
      end
      INC_HOLD: begin
        if (inc_fall_c) begin
          ev_short_c = (hold_q < HOLD_LIM);
          state_d    = INC_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          ev_long_c = 1'b1;
          state_d   = INC_LONG;
        end else if (hold_q != CNT_MAX) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      INC_LONG: begin
        if (inc_fall_c) state_d = INC_IDLE;
      end
      default: state_d = INC_IDLE;
    endcase
  end

  logic [3:0] pend_q, new_c, grant_c, left_c, out_q;
  logic       pending_q;

  assign new_c = {set_rise_c, sw_rise_c, ev_long_c, ev_short_c};

  always_comb begin
    grant_c = '0;
    if      (pend_q[P_SET])   grant_c[P_SET]   = 1'b1;
    else if (pend_q[P_SW])    grant_c[P_SW]    = 1'b1;
    else if (pend_q[P_LONG])  grant_c[P_LONG]  = 1'b1;
    else if (pend_q[P_SHORT]) grant_c[P_SHORT] = 1'b1;
    left_c = pend_q & ~grant_c;
  end

  // Issue one queued event per cycle; a repeat of a queued type merges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      out_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      pend_q    <= left_c | new_c;
      out_q     <= grant_c;
      pending_q <= |left_c;
    end
  end

  assign evt.inc_short     = out_q[P_SHORT];
  assign evt.inc_long      = out_q[P_LONG];
  assign evt.set           = out_q[P_SET];
  assign evt.sw            = out_q[P_SW];
  assign evt.event_pending = pending_q;

endmodule
